// File: rtl/mem_test_pkg.sv
// mem_test_pkg: shared widths, checker states, display constant and the test pattern
package mem_test_pkg;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 16;
  localparam int PAT_W = 64;
  localparam logic [15:0] DISP_BUSY = 16'hC0DE;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} checkState_t;
  function automatic logic [PAT_W-1:0] expected(input logic [PAT_W-1:0] addr, input logic [PAT_W-1:0] seed);
    return addr ^ seed;
  endfunction
endpackage

// File: rtl/mem_rd_delay_line.sv
// mem_rd_delay_line: DEPTH-deep valid/address shift register with synchronous clear
module mem_rd_delay_line #(
  parameter int ADDR_W = 15,
  parameter int DEPTH = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              inValid,
  input  logic [ADDR_W-1:0] inAddr,
  output logic              outValid,
  output logic [ADDR_W-1:0] outAddr,
  output logic              anyValid
);
  logic [DEPTH-1:0] validQ;
  logic [ADDR_W-1:0] addrQ [DEPTH];
  always_ff @(posedge clock) begin
    validQ[0] <= clear ? 1'b0 : inValid;
    addrQ[0] <= inAddr;
    for (int i = 1; i < DEPTH; i++) begin
      validQ[i] <= clear ? 1'b0 : validQ[i-1];
      addrQ[i] <= addrQ[i-1];
    end
  end
  assign outValid = validQ[DEPTH-1];
  assign outAddr = addrQ[DEPTH-1];
  assign anyValid = |validQ;
endmodule

// File: rtl/mem_readback_checker.sv
// mem_readback_checker: sweeps port B and checks words against the write pattern; MISMATCH_HALT_EN stops on the first mismatch
module mem_readback_checker
  import mem_test_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int READ_LAT = 1,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DATA_W-1:0] seed,
  output logic              enB,
  output logic [ADDR_W-1:0] AddressB,
  input  logic [DATA_W-1:0] ReadDataB,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [15:0]       disp_num
);
  checkState_t state, nextState;
  logic [ADDR_W-1:0] cur, lastQ, cmpAddr;
  logic [DATA_W-1:0] seedQ;
  logic cmpValid, pipeBusy, mismatch, countErr, halt, pushValid;
  mem_rd_delay_line #(.ADDR_W(ADDR_W), .DEPTH(READ_LAT)) u_delay (
    .clock(clock),
    .clear(!reset_n),
    .inValid(pushValid),
    .inAddr(cur),
    .outValid(cmpValid),
    .outAddr(cmpAddr),
    .anyValid(pipeBusy)
  );
  assign mismatch = cmpValid && (ReadDataB != DATA_W'(expected(PAT_W'(cmpAddr), PAT_W'(seedQ))));
`ifdef MISMATCH_HALT_EN
  // after the first error, compares of reads still in flight are dropped
  assign countErr = mismatch && (err_count == '0);
  assign halt = countErr;
`else
  assign countErr = mismatch;
  assign halt = 1'b0;
`endif
  always_comb begin
    nextState = state;
    enB = 1'b0;
    pushValid = 1'b0;
    nextState = state == IDLE  ? (start ? ISSUE : IDLE) :
                state == ISSUE ? ((cur == lastQ || halt) ? DRAIN : ISSUE) :
                state == DRAIN ? (pipeBusy ? DRAIN : DONE) : IDLE;
    enB = state == ISSUE;
    pushValid = (state == ISSUE) && !halt;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cur <= '0;
      lastQ <= '0;
      seedQ <= '0;
      pass <= 1'b0;
      err_count <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && start) begin
        cur <= base_addr;
        lastQ <= last_addr;
        seedQ <= seed;
        pass <= 1'b0;
        err_count <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else begin
        if (state == ISSUE) cur <= cur + ADDR_W'(1);
        if (countErr && err_count != '1) err_count <= err_count + CNT_W'(1);
        if (countErr && err_count == '0) begin
          first_err_addr <= cmpAddr;
          first_err_data <= ReadDataB;
        end
        if (state == DONE) pass <= err_count == '0;
      end
    end
  end
  assign AddressB = cur;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign disp_num = busy ? DISP_BUSY : pass ? 16'h0000 : 16'(err_count);
endmodule
